biriscv_fetch_linebuf: RTL and testbench

Small direct-mapped instruction line buffer that services the fetch unit's 64-bit icache request port and fills misses from a single-outstanding 64-bit memory read port. It sits directly upstream of the frontend and drives its icache_* inputs. A hit returns the next cycle with back-to-back pipelining. A miss stalls the port until the memory fill returns.

---
 rtl/biriscv_fetch_linebuf.sv | 139 +++++++++++++
 tb/tb_biriscv_fetch_linebuf.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_fetch_linebuf.sv
// Direct-mapped 64-bit instruction line buffer in front of the fetch unit's icache port.
// Hits answer one cycle after accept; misses fetch one line over a single-outstanding read port.
module biriscv_fetch_linebuf #(
  parameter int NUM_LINES   = 4,
  parameter int NUM_LINES_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        icache_rd_i,
  input  logic        icache_flush_i,
  input  logic        icache_invalidate_i,
  input  logic [31:0] icache_pc_i,
  input  logic [1:0]  icache_priv_i,
  output logic        icache_accept_o,
  output logic        icache_valid_o,
  output logic        icache_error_o,
  output logic [63:0] icache_inst_o,
  output logic        icache_page_fault_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic        mem_error_i,
  input  logic [63:0] mem_data_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam int TAG_W = 32 - 3 - NUM_LINES_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    MISS_REQ  = 2'd2,
    MISS_WAIT = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t                 state_q;
  logic [31:0]            pc_p1;
  logic [1:0]             priv_p1;
  logic                   drop_fill_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [63:0]            data_q [NUM_LINES];
  logic [31:0]            hit_cnt_q;
  logic [31:0]            miss_cnt_q;

  logic                   flush_any;
  logic [NUM_LINES_W-1:0] idx;
  logic [TAG_W-1:0]       pc_tag;
  logic                   hit;
  logic                   fill;
  logic                   take;
  logic                   line_wr;
  logic                   unused_ok;

  assign flush_any = icache_flush_i | icache_invalidate_i;
  assign idx       = pc_p1[3 +: NUM_LINES_W];
  assign pc_tag    = pc_p1[31:3+NUM_LINES_W];
  assign hit       = (state_q == LOOKUP) && valid_q[idx] && (tag_q[idx] == pc_tag);
  assign fill      = mem_valid_i &&
                     ((state_q == MISS_WAIT) || ((state_q == MISS_REQ) && mem_accept_i));
  assign take      = icache_rd_i && icache_accept_o;
  // A flush anywhere between the miss and its fill (including this cycle) blocks allocation.
  assign line_wr   = fill && !mem_error_i && !drop_fill_q && !flush_any;

  assign icache_accept_o     = !flush_any && ((state_q == IDLE) || hit);
  assign icache_valid_o      = hit || fill;
  assign icache_error_o      = fill && mem_error_i;
  assign icache_inst_o       = fill ? mem_data_i : (hit ? data_q[idx] : 64'd0);
  assign icache_page_fault_o = 1'b0;
  assign mem_rd_o            = (state_q == MISS_REQ);
  assign mem_addr_o          = {pc_p1[31:3], 3'b000};
  assign hit_count_o         = hit_cnt_q;
  assign miss_count_o        = miss_cnt_q;

  assign unused_ok = ^{icache_pc_i[2:0], pc_p1[2:0], priv_p1};

  // Lookup stage: request capture, line state and the miss sequencer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pc_p1       <= 32'd0;
      priv_p1     <= 2'd0;
      drop_fill_q <= 1'b0;
      valid_q     <= '0;
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      if (take) begin
        pc_p1   <= icache_pc_i;
        priv_p1 <= icache_priv_i;
      end

      case (state_q)
        IDLE: begin
          if (take) state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
            state_q   <= take ? LOOKUP : IDLE;
          end else begin
            miss_cnt_q  <= sat_inc(miss_cnt_q);
            drop_fill_q <= flush_any;
            state_q     <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (flush_any) drop_fill_q <= 1'b1;
          if (mem_accept_i) state_q <= mem_valid_i ? IDLE : MISS_WAIT;
        end
        MISS_WAIT: begin
          if (flush_any) drop_fill_q <= 1'b1;
          if (mem_valid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (flush_any)
        valid_q <= '0;
      else if (line_wr)
        valid_q[idx] <= 1'b1;
    end
  end

  // Fill stage: tag and data arrays carry no reset, the valid bits qualify them
  always_ff @(posedge clk_i) begin
    if (line_wr) begin
      tag_q[idx]  <= pc_tag;
      data_q[idx] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_biriscv_fetch_linebuf.sv
// Scoreboard bench for biriscv_fetch_linebuf: responses are queued at request time
// and popped when icache_valid_o pulses; counters and handshakes checked inline.
module tb_biriscv_fetch_linebuf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        icache_rd_i;
  logic        icache_flush_i;
  logic        icache_invalidate_i;
  logic [31:0] icache_pc_i;
  logic [1:0]  icache_priv_i;
  logic        icache_accept_o;
  logic        icache_valid_o;
  logic        icache_error_o;
  logic [63:0] icache_inst_o;
  logic        icache_page_fault_o;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic        mem_accept_i;
  logic        mem_valid_i;
  logic        mem_error_i;
  logic [63:0] mem_data_i;
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [64:0] sb_q[$];

  localparam logic [63:0] D1 = 64'h0000_0013_0000_0093;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D3 = 64'hBAD0_BAD0_BAD0_BAD0;
  localparam logic [63:0] D4 = 64'h0000_0100_0000_0101;
  localparam logic [63:0] D5 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DB = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D6 = 64'h0123_4567_89AB_CDEF;

  biriscv_fetch_linebuf #(.NUM_LINES(4), .NUM_LINES_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .icache_rd_i(icache_rd_i), .icache_flush_i(icache_flush_i),
    .icache_invalidate_i(icache_invalidate_i), .icache_pc_i(icache_pc_i),
    .icache_priv_i(icache_priv_i), .icache_accept_o(icache_accept_o),
    .icache_valid_o(icache_valid_o), .icache_error_o(icache_error_o),
    .icache_inst_o(icache_inst_o), .icache_page_fault_o(icache_page_fault_o),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_accept_i(mem_accept_i),
    .mem_valid_i(mem_valid_i), .mem_error_i(mem_error_i), .mem_data_i(mem_data_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Response monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    #2;
    checks++;
    if (icache_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected actual inst=%h err=%b required no response",
                 icache_inst_o, icache_error_o);
      end else begin
        logic [64:0] exp;
        exp = sb_q.pop_front();
        if ({icache_error_o, icache_inst_o} !== exp) begin
          errors++;
          $display("FAIL resp_data actual err=%b inst=%h required err=%b inst=%h",
                   icache_error_o, icache_inst_o, exp[64], exp[63:0]);
        end
      end
    end else if (icache_inst_o !== 64'd0 || icache_error_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs actual inst=%h err=%b required 0 0",
               icache_inst_o, icache_error_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] pc, input logic push,
                       input logic exp_err, input logic [63:0] exp_data);
    @(negedge clk_i);
    icache_rd_i = 1'b1;
    icache_pc_i = pc;
    #1;
    checks++;
    if (icache_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_accept pc=%h actual %b required 1", pc, icache_accept_o);
    end
    if (push) sb_q.push_back({exp_err, exp_data});
    @(negedge clk_i);
    icache_rd_i = 1'b0;
  endtask

  // Waits for the miss request, then accepts after acc_dly cycles and returns
  // data resp_dly cycles after the accept cycle (0 = same cycle as accept).
  task automatic serve_fill(input int acc_dly, input int resp_dly, input logic [63:0] data,
                            input logic err, input logic [31:0] exp_addr);
    int n;
    n = 0;
    @(negedge clk_i);
    #1;
    while (mem_rd_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    checks++;
    if (mem_rd_o !== 1'b1) begin
      errors++;
      $display("FAIL mem_rd_timeout addr=%h actual %b required 1", exp_addr, mem_rd_o);
      return;
    end
    checks++;
    if (mem_addr_o !== exp_addr) begin
      errors++;
      $display("FAIL mem_addr actual %h required %h", mem_addr_o, exp_addr);
    end
    for (int i = 0; i < acc_dly; i++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (mem_rd_o !== 1'b1 || mem_addr_o !== exp_addr) begin
        errors++;
        $display("FAIL mem_rd_held actual rd=%b addr=%h required 1 %h", mem_rd_o, mem_addr_o, exp_addr);
      end
    end
    mem_accept_i = 1'b1;
    if (resp_dly == 0) begin
      mem_valid_i = 1'b1;
      mem_data_i  = data;
      mem_error_i = err;
    end
    @(negedge clk_i);
    mem_accept_i = 1'b0;
    mem_valid_i  = 1'b0;
    mem_data_i   = 64'd0;
    mem_error_i  = 1'b0;
    if (resp_dly > 0) begin
      repeat (resp_dly - 1) @(negedge clk_i);
      mem_valid_i = 1'b1;
      mem_data_i  = data;
      mem_error_i = err;
      @(negedge clk_i);
      mem_valid_i = 1'b0;
      mem_data_i  = 64'd0;
      mem_error_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    icache_rd_i = 0; icache_flush_i = 0; icache_invalidate_i = 0;
    icache_pc_i = 0; icache_priv_i = 2'd3;
    mem_accept_i = 0; mem_valid_i = 0; mem_error_i = 0; mem_data_i = 0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (icache_accept_o !== 1'b1) begin
      errors++; $display("FAIL reset_accept actual %b required 1", icache_accept_o);
    end
    checks++;
    if ({icache_valid_o, icache_error_o, icache_page_fault_o, mem_rd_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags actual %b required 0000",
               {icache_valid_o, icache_error_o, icache_page_fault_o, mem_rd_o});
    end
    checks++;
    if (icache_inst_o !== 64'd0 || mem_addr_o !== 32'd0) begin
      errors++; $display("FAIL reset_buses actual %h %h required 0 0", icache_inst_o, mem_addr_o);
    end
    checks++;
    if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin
      errors++; $display("FAIL reset_counters actual %0d %0d required 0 0", hit_count_o, miss_count_o);
    end
  endtask

  task automatic test_cold_miss();
    issue(32'h8000_0000, 1'b1, 1'b0, D1);
    serve_fill(1, 3, D1, 1'b0, 32'h8000_0000);
    exp_misses++;
    @(negedge clk_i);
    #1;
    checks++;
    if (miss_count_o !== exp_misses || hit_count_o !== exp_hits) begin
      errors++;
      $display("FAIL cold_counters actual %0d/%0d required %0d/%0d",
               hit_count_o, miss_count_o, exp_hits, exp_misses);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    icache_rd_i = 1'b1;
    icache_pc_i = 32'h8000_0000;
    #1;
    checks++;
    if (icache_accept_o !== 1'b1) begin
      errors++; $display("FAIL b2b_accept0 actual %b required 1", icache_accept_o);
    end
    sb_q.push_back({1'b0, D1});
    @(negedge clk_i);
    icache_pc_i = 32'h8000_0004;
    #1;
    checks++;
    if (icache_accept_o !== 1'b1 || icache_valid_o !== 1'b1 || mem_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cycle1 actual acc=%b vld=%b rd=%b required 1 1 0",
               icache_accept_o, icache_valid_o, mem_rd_o);
    end
    sb_q.push_back({1'b0, D1});
    @(negedge clk_i);
    icache_rd_i = 1'b0;
    #1;
    checks++;
    if (icache_valid_o !== 1'b1 || mem_rd_o !== 1'b0) begin
      errors++; $display("FAIL b2b_cycle2 actual vld=%b rd=%b required 1 0", icache_valid_o, mem_rd_o);
    end
    exp_hits += 2;
    @(negedge clk_i);
    #1;
    checks++;
    if (icache_valid_o !== 1'b0 || hit_count_o !== exp_hits || mem_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after actual vld=%b hits=%0d rd=%b required 0 %0d 0",
               icache_valid_o, hit_count_o, mem_rd_o, exp_hits);
    end
  endtask

  task automatic test_conflict();
    issue(32'h8000_0020, 1'b1, 1'b0, D2);
    serve_fill(0, 1, D2, 1'b0, 32'h8000_0020);
    issue(32'h8000_0000, 1'b1, 1'b0, D1);
    serve_fill(0, 0, D1, 1'b0, 32'h8000_0000);
    exp_misses += 2;
    checks++;
    if (miss_count_o !== exp_misses) begin
      errors++; $display("FAIL conflict_misses actual %0d required %0d", miss_count_o, exp_misses);
    end
    issue(32'h8000_0004, 1'b1, 1'b0, D1);
    exp_hits++;
    @(negedge clk_i);
    #1;
    checks++;
    if (hit_count_o !== exp_hits || miss_count_o !== exp_misses) begin
      errors++;
      $display("FAIL conflict_refill_hit actual %0d/%0d required %0d/%0d",
               hit_count_o, miss_count_o, exp_hits, exp_misses);
    end
  endtask

  task automatic test_error();
    issue(32'h0000_0100, 1'b1, 1'b1, D3);
    serve_fill(0, 2, D3, 1'b1, 32'h0000_0100);
    issue(32'h0000_0100, 1'b1, 1'b0, D4);
    serve_fill(0, 1, D4, 1'b0, 32'h0000_0100);
    exp_misses += 2;
    @(negedge clk_i);
    #1;
    checks++;
    if (miss_count_o !== exp_misses) begin
      errors++; $display("FAIL error_refetch_misses actual %0d required %0d", miss_count_o, exp_misses);
    end
  endtask

  task automatic test_flush_in_miss();
    // Flush in IDLE blocks acceptance for that cycle.
    @(negedge clk_i);
    icache_rd_i = 1'b1;
    icache_invalidate_i = 1'b1;
    icache_pc_i = 32'h8000_0008;
    #1;
    checks++;
    if (icache_accept_o !== 1'b0) begin
      errors++; $display("FAIL flush_accept actual %b required 0", icache_accept_o);
    end
    @(negedge clk_i);
    icache_rd_i = 1'b0;
    icache_invalidate_i = 1'b0;
    issue(32'h8000_0008, 1'b1, 1'b0, D5);
    serve_fill(1, 1, D5, 1'b0, 32'h8000_0008);
    issue(32'h8000_000C, 1'b1, 1'b0, D5);
    exp_misses++;
    exp_hits++;
    issue(32'h8000_0010, 1'b1, 1'b0, DB);
    exp_misses++;
    @(negedge clk_i);
    #1;
    checks++;
    if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h8000_0010) begin
      errors++; $display("FAIL flush_miss_req actual rd=%b addr=%h required 1 80000010", mem_rd_o, mem_addr_o);
    end
    mem_accept_i = 1'b1;
    @(negedge clk_i);
    mem_accept_i = 1'b0;
    icache_flush_i = 1'b1;
    @(negedge clk_i);
    icache_flush_i = 1'b0;
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem_data_i  = DB;
    #1;
    checks++;
    if (icache_valid_o !== 1'b1) begin
      errors++; $display("FAIL flush_resp_delivered actual %b required 1", icache_valid_o);
    end
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    mem_data_i  = 64'd0;
    issue(32'h8000_0010, 1'b1, 1'b0, D6);
    serve_fill(0, 1, D6, 1'b0, 32'h8000_0010);
    issue(32'h8000_0008, 1'b1, 1'b0, D5);
    serve_fill(0, 0, D5, 1'b0, 32'h8000_0008);
    issue(32'h8000_0020, 1'b1, 1'b0, D2);
    serve_fill(0, 1, D2, 1'b0, 32'h8000_0020);
    exp_misses += 3;
    @(negedge clk_i);
    #1;
    checks++;
    if (hit_count_o !== exp_hits || miss_count_o !== exp_misses) begin
      errors++;
      $display("FAIL flush_counters actual %0d/%0d required %0d/%0d",
               hit_count_o, miss_count_o, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset_mid_miss();
    issue(32'h0000_0200, 1'b0, 1'b0, 64'd0);
    @(negedge clk_i);
    #1;
    checks++;
    if (mem_rd_o !== 1'b1) begin
      errors++; $display("FAIL rstmiss_req actual %b required 1", mem_rd_o);
    end
    mem_accept_i = 1'b1;
    @(negedge clk_i);
    mem_accept_i = 1'b0;
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (icache_accept_o !== 1'b1 || icache_valid_o !== 1'b0 || mem_rd_o !== 1'b0 ||
        mem_addr_o !== 32'd0 || icache_inst_o !== 64'd0) begin
      errors++;
      $display("FAIL rstmiss_outputs actual acc=%b vld=%b rd=%b addr=%h required 1 0 0 0",
               icache_accept_o, icache_valid_o, mem_rd_o, mem_addr_o);
    end
    checks++;
    if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin
      errors++; $display("FAIL rstmiss_counters actual %0d %0d required 0 0", hit_count_o, miss_count_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem_data_i  = 64'hFFFF_0000_FFFF_0000;
    #3;
    checks++;
    if (icache_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstmiss_stray actual %b required 0", icache_valid_o);
    end
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    mem_data_i  = 64'd0;
    #1;
    checks++;
    if (icache_accept_o !== 1'b1) begin
      errors++; $display("FAIL rstmiss_idle actual %b required 1", icache_accept_o);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_error();
    test_flush_in_miss();
    test_reset_mid_miss();
    repeat (2) @(negedge clk_i);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain actual %0d pending required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
